// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: sequencer for the ADC -> TMU sample path.
// Enables the capture path, waits for it to settle, issues periodic
// conversion starts, averages 2^AVG_LOG2 samples and presents the result
// on a valid/ready interface. Missed ticks and overwritten results raise
// the sticky overrun flag.
// Optional feature: define ADC_TIMEOUT_EN to add a conversion timeout that
// raises the sticky err_timeout flag; otherwise err_timeout is tied low.
module adc_sample_ctrl #(
   parameter int DATA_W      = 12,
   parameter int PERIOD_W    = 16,
   parameter int AVG_LOG2    = 2,
   parameter int SETTLE_CYC  = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic                ovr_clr,
   output logic                adc_start,
   input  logic                adc_done,
   input  logic [DATA_W-1:0]   adc_data,
   output logic                adc2tmu_en,
   output logic [DATA_W-1:0]   avg_data,
   output logic                avg_valid,
   input  logic                avg_ready,
   output logic                busy,
   output logic                overrun,
   output logic                err_timeout
);

   // Accumulator is wide enough to hold 2^AVG_LOG2 full-scale samples.
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC);

   // Reject parameter sets the counters below cannot represent.
   if (AVG_LOG2 < 1 || SETTLE_CYC < 0 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("adc_sample_ctrl: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_CONVERT,
      S_WAIT_TICK
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [SET_W-1:0]    settle_cnt;
   logic [PERIOD_W-1:0] period_cnt;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] period_eff;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [AVG_LOG2-1:0] cnt;
   logic                running;
   logic                tick;
   logic                take;
   logic                publish;
   logic                missed;
   logic                overwrite;
`ifdef ADC_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0]     to_cnt;
   logic                timeout_hit;
`endif

   // A zero period behaves as a period of one cycle.
   assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
   assign running    = (state == S_START) || (state == S_CONVERT) || (state == S_WAIT_TICK);
   assign tick       = running && (period_cnt == period_q - PERIOD_W'(1));
   assign acc_sum    = acc + ACC_W'(adc_data);
   assign publish    = take && (cnt == '1);
   assign overwrite  = publish && avg_valid && !avg_ready;

   assign adc_start  = (state == S_START);
   assign adc2tmu_en = (state != S_IDLE);
   assign busy       = (state != S_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rstn) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state decode plus the per-cycle sample/missed-tick strobes.
   always_comb begin
      // NOTE: defaults first, so no path leaves a variable unassigned (no latch).
      next_state  = state;
      take        = 1'b0;
      missed      = 1'b0;
`ifdef ADC_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         S_IDLE:      if (enable) next_state = S_SETTLE;
         S_SETTLE:    if (settle_cnt == SETTLE_LAST) next_state = S_START;
         S_START: begin
            missed     = tick;
            next_state = S_CONVERT;
         end
         S_CONVERT: begin
            // A tick landing together with adc_done is still a missed tick.
            missed = tick;
            if (adc_done) begin
               take       = 1'b1;
               next_state = S_WAIT_TICK;
            end
`ifdef ADC_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               next_state  = S_WAIT_TICK;
            end
`endif
         end
         S_WAIT_TICK: if (tick) next_state = S_START;
         default:     next_state = S_IDLE;
      endcase
      // Dropping enable aborts from any state and discards the sample.
      if (!enable) begin
         next_state  = S_IDLE;
         take        = 1'b0;
`ifdef ADC_TIMEOUT_EN
         timeout_hit = 1'b0;
`endif
      end
   end

   // Settle counter: runs only while the capture path fills.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  settle_cnt <= '0;
      else if (state == S_SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                        settle_cnt <= '0;
   end

   // Period counter: held at zero until sampling starts; the period input is
   // re-latched at every wrap so a change takes effect on the next period.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         period_cnt <= '0;
         period_q   <= PERIOD_W'(1);
      end else if (!running) begin
         period_cnt <= '0;
         period_q   <= period_eff;
      end else if (tick) begin
         period_cnt <= '0;
         period_q   <= period_eff;
      end else begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

   // Accumulator and sample count; cleared on publish or when disabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc <= '0;
         cnt <= '0;
      end else if (!enable) begin
         acc <= '0;
         cnt <= '0;
      end else if (take) begin
         if (publish) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Result register: newest average always loads; valid drops after a handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         avg_data  <= '0;
         avg_valid <= 1'b0;
      end else if (publish) begin
         avg_data  <= DATA_W'(acc_sum >> AVG_LOG2);
         avg_valid <= 1'b1;
      end else if (avg_valid && avg_ready) begin
         avg_valid <= 1'b0;
      end
   end

   // Sticky overrun: a set event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                      overrun <= 1'b0;
      else if (missed || overwrite)   overrun <= 1'b1;
      else if (ovr_clr)               overrun <= 1'b0;
   end

`ifdef ADC_TIMEOUT_EN
   // Timeout counter: counts cycles spent waiting in CONVERT.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                   to_cnt <= '0;
      else if (state == S_CONVERT) to_cnt <= to_cnt + 1'b1;
      else                         to_cnt <= '0;
   end

   // Sticky timeout flag: a set event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)            err_timeout <= 1'b0;
      else if (timeout_hit) err_timeout <= 1'b1;
      else if (ovr_clr)     err_timeout <= 1'b0;
   end
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb_adc_sample_ctrl: directed bench for adc_sample_ctrl.
// A cycle table covers reset release, periodic sampling, averaging and
// result overwrite; hand-written sequences cover missed ticks, enable
// abort, simultaneous publish/handshake and the conversion timeout.
module tb_adc_sample_ctrl;

   localparam int N_VEC = 121;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic [15:0] period;
   logic        ovr_clr;
   logic        adc_start;
   logic        adc_done;
   logic [11:0] adc_data;
   logic        adc2tmu_en;
   logic [11:0] avg_data;
   logic        avg_valid;
   logic        avg_ready;
   logic        busy;
   logic        overrun;
   logic        err_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic        in_done;
      logic [11:0] in_data;
      logic        in_ready;
      logic        in_clr;
      logic        in_en;
      logic        x_en;
      logic        x_start;
      logic        x_valid;
      logic [11:0] x_data;
      logic        x_ovr;
   } vec_t;

   vec_t        vecs [1:N_VEC];
   logic [11:0] samp [12];

   adc_sample_ctrl dut (
      .clk         (clk),
      .rstn        (rstn),
      .enable      (enable),
      .period      (period),
      .ovr_clr     (ovr_clr),
      .adc_start   (adc_start),
      .adc_done    (adc_done),
      .adc_data    (adc_data),
      .adc2tmu_en  (adc2tmu_en),
      .avg_data    (avg_data),
      .avg_valid   (avg_valid),
      .avg_ready   (avg_ready),
      .busy        (busy),
      .overrun     (overrun),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, want);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick_cyc();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Step until adc_start is seen, bounded by a cycle budget.
   task automatic wait_start(input int budget);
      int n = 0;
      while (adc_start !== 1'b1 && n < budget) begin
         tick_cyc();
         n++;
      end
      check("adc_start within budget", adc_start, 1);
   endtask

   // Called on an adc_start cycle: answer with adc_done three cycles later.
   task automatic do_sample(input logic [11:0] d, input logic rdy);
      repeat (3) tick_cyc();
      adc_done  = 1'b1;
      adc_data  = d;
      avg_ready = rdy;
      tick_cyc();
      adc_done  = 1'b0;
      adc_data  = '0;
      avg_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_extra;

      samp = '{12'd100, 12'd101, 12'd102, 12'd105,
               12'h800, 12'h800, 12'h800, 12'h800,
               12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

      // Cycle table: starts every 10 cycles from cycle 4, adc_done 3 cycles
      // after each start, 12 samples (three averages).
      for (int c = 1; c <= N_VEC; c++) begin
         vecs[c].in_done  = (c >= 7) && ((c - 7) % 10 == 0) && (c <= 117);
         vecs[c].in_data  = vecs[c].in_done ? samp[(c - 7) / 10] : 12'd0;
         vecs[c].in_ready = (c == 38);
         vecs[c].in_clr   = (c == 118);
         vecs[c].in_en    = (c != N_VEC);
         vecs[c].x_en     = 1'b1;
         vecs[c].x_start  = (c >= 4) && ((c - 4) % 10 == 0);
         vecs[c].x_valid  = (c == 38) || (c >= 78);
         if (c < 38)       vecs[c].x_data = 12'd0;
         else if (c < 78)  vecs[c].x_data = 12'd102;
         else if (c < 118) vecs[c].x_data = 12'h800;
         else              vecs[c].x_data = 12'hFFF;
         vecs[c].x_ovr    = (c == 118);
      end

      rstn      = 1'b0;
      enable    = 1'b1;
      period    = 16'd10;
      ovr_clr   = 1'b0;
      adc_done  = 1'b0;
      adc_data  = '0;
      avg_ready = 1'b0;

      // Reset held with enable high: every output stays low.
      repeat (3) begin
         tick_cyc();
         check("reset adc_start",   adc_start,   0);
         check("reset adc2tmu_en",  adc2tmu_en,  0);
         check("reset busy",        busy,        0);
         check("reset avg_valid",   avg_valid,   0);
         check("reset avg_data",    avg_data,    0);
         check("reset overrun",     overrun,     0);
         check("reset err_timeout", err_timeout, 0);
      end
      rstn = 1'b1;
      cyc  = 0;

      for (int c = 1; c <= N_VEC; c++) begin
         tick_cyc();
         check("vec adc2tmu_en",  adc2tmu_en,  vecs[c].x_en);
         check("vec busy",        busy,        vecs[c].x_en);
         check("vec adc_start",   adc_start,   vecs[c].x_start);
         check("vec avg_valid",   avg_valid,   vecs[c].x_valid);
         check("vec avg_data",    avg_data,    vecs[c].x_data);
         check("vec overrun",     overrun,     vecs[c].x_ovr);
         check("vec err_timeout", err_timeout, 0);
         adc_done  = vecs[c].in_done;
         adc_data  = vecs[c].in_data;
         avg_ready = vecs[c].in_ready;
         ovr_clr   = vecs[c].in_clr;
         enable    = vecs[c].in_en;
      end

      // Enable dropped: idle next cycle, pending result held until consumed.
      tick_cyc();
      check("disable adc2tmu_en", adc2tmu_en, 0);
      check("disable busy",       busy,       0);
      check("held avg_valid",     avg_valid,  1);
      check("held avg_data",      avg_data,   12'hFFF);
      avg_ready = 1'b1;
      tick_cyc();
      check("consume avg_valid",  avg_valid,  0);
      avg_ready = 1'b0;

      // period=2, adc_done 5 cycles after start: ticks at +1,+3,+5 are missed.
      period = 16'd2;
      enable = 1'b1;
      wait_start(20);
      for (int k = 1; k <= 8; k++) begin
         tick_cyc();
         if (k < 8) check("no adc_start in convert", adc_start, 0);
         else       check("adc_start after missed ticks", adc_start, 1);
         if (k == 1) check("overrun before miss", overrun, 0);
         if (k == 2) check("overrun on missed tick", overrun, 1);
         if (k == 5) begin
            adc_done = 1'b1;
            adc_data = 12'd7;
         end
         if (k == 6) begin
            adc_done = 1'b0;
            adc_data = '0;
         end
      end
      enable  = 1'b0;
      period  = 16'd10;
      ovr_clr = 1'b1;
      tick_cyc();
      ovr_clr = 1'b0;
      check("idle after disable", busy, 0);
      check("ovr_clr clears overrun", overrun, 0);

      // Two of four samples, then abort; a late adc_done must be ignored.
      enable = 1'b1;
      wait_start(20);
      do_sample(12'd900, 1'b0);
      wait_start(20);
      do_sample(12'd900, 1'b0);
      enable = 1'b0;
      tick_cyc();
      check("abort adc2tmu_en", adc2tmu_en, 0);
      check("abort busy",       busy,       0);
      adc_done = 1'b1;
      adc_data = 12'd4000;
      tick_cyc();
      adc_done = 1'b0;
      adc_data = '0;
      check("stray done ignored busy",  busy,      0);
      check("stray done no publish",    avg_valid, 0);

      // Fresh average of 50s, then 60s published during a handshake.
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_start(20);
         do_sample(12'd50, 1'b0);
      end
      check("clean avg_valid", avg_valid, 1);
      check("clean avg_data",  avg_data,  12'd50);
      check("clean overrun",   overrun,   0);
      for (int i = 0; i < 4; i++) begin
         wait_start(20);
         do_sample(12'd60, (i == 3));
      end
      check("publish+handshake avg_valid", avg_valid, 1);
      check("publish+handshake avg_data",  avg_data,  12'd60);
      check("publish+handshake overrun",   overrun,   0);
      avg_ready = 1'b1;
      tick_cyc();
      avg_ready = 1'b0;
      check("final consume avg_valid", avg_valid, 0);

      // adc_done never arrives.
      wait_start(20);
      n_extra = 0;
`ifdef ADC_TIMEOUT_EN
      for (int k = 1; k <= 260; k++) begin
         tick_cyc();
         if (k < 260 && adc_start) n_extra++;
         if (k == 255) check("no timeout yet", err_timeout, 0);
         if (k == 256) check("timeout flagged", err_timeout, 1);
      end
      check("adc_start on tick after timeout", adc_start, 1);
      check("no early restart", n_extra, 0);
      ovr_clr = 1'b1;
      tick_cyc();
      ovr_clr = 1'b0;
      check("ovr_clr clears err_timeout", err_timeout, 0);
`else
      for (int k = 1; k <= 300; k++) begin
         tick_cyc();
         if (adc_start) n_extra++;
      end
      check("stuck no restart",   n_extra,     0);
      check("stuck busy",         busy,        1);
      check("stuck adc2tmu_en",   adc2tmu_en,  1);
      check("stuck err_timeout",  err_timeout, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_sample_ctrl.md
Name: adc_sample_ctrl

Overview:
- Sequencer for the ADC-to-TMU sample path in the PID accelerator.
- Gates the 12-bit ADC capture path with adc2tmu_en, waits out the path's settle time, then issues periodic conversion starts.
- Collects 2^AVG_LOG2 results, averages them, and hands the result to the PID core over a valid/ready handshake.
- Sits between the ADC front end / adc2tmu capture registers and the PID error stage.

Parameters:
- DATA_W, 12, ADC sample width.
- PERIOD_W, 16, width of the sample-period input.
- AVG_LOG2, 2, log2 of samples per average (4 samples).
- SETTLE_CYC, 2, cycles between adc2tmu_en rising and the first adc_start; matches the 2-stage capture path.
- TIMEOUT_CYC, 255, conversion timeout in clk cycles. Used only with ADC_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- enable  in  1  run request, level
- period  in  PERIOD_W  sample period in clk cycles; 0 is treated as 1
- ovr_clr  in  1  clears overrun and err_timeout, single-cycle pulse
- adc_start  out  1  conversion start, one-cycle pulse
- adc_done  in  1  conversion complete; adc_data valid in the same cycle
- adc_data  in  DATA_W  captured sample from the adc2tmu path
- adc2tmu_en  out  1  enable for the capture path
- avg_data  out  DATA_W  averaged result
- avg_valid  out  1  avg_data valid
- avg_ready  in  1  consumer accepts
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: tick missed, or unconsumed result overwritten
- err_timeout  out  1  sticky conversion timeout

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Accumulator, sample count, period counter and settle counter are cleared.
- States: IDLE, SETTLE, START, CONVERT, WAIT_TICK.
- IDLE: adc2tmu_en=0. When enable=1, go to SETTLE; adc2tmu_en=1 from the next cycle.
- SETTLE: count SETTLE_CYC cycles with adc2tmu_en=1, then go to START. The period counter is cleared on leaving SETTLE.
- START: adc_start=1 for exactly one cycle, then go to CONVERT.
- CONVERT: wait for adc_done.
  - On adc_done: acc <= acc + adc_data; cnt <= cnt + 1.
  - If cnt was 2^AVG_LOG2-1, publish the result: avg_data <= (acc + adc_data) >> AVG_LOG2, avg_valid <= 1, then clear acc and cnt.
  - After adc_done, go to WAIT_TICK.
- Period counter:
  - Free-runs whenever the FSM is in START, CONVERT or WAIT_TICK.
  - A tick fires when the counter reaches max(period,1)-1; the counter then wraps to 0.
  - A period change takes effect at the next wrap.
- WAIT_TICK: on a tick, go to START.
  - Tick and adc_done in the same cycle while in CONVERT: the tick counts as missed.
- Missed tick: a tick in any state other than WAIT_TICK (START, CONVERT) sets overrun and is dropped. The FSM then waits for the next tick.
- Accumulator width: DATA_W+AVG_LOG2 bits, so it cannot overflow. The average is truncated, not rounded.
- Output handshake:
  - avg_valid stays high until avg_valid && avg_ready, then clears the next cycle.
  - If a new result publishes while avg_valid=1 and avg_ready=0, avg_data is overwritten with the newest value, avg_valid stays 1, and overrun is set.
  - If a publish and a handshake occur in the same cycle, the new data loads, avg_valid stays 1, and overrun is not set.
- Sticky flags: overrun and err_timeout clear only on ovr_clr or reset. If ovr_clr and a set event occur in the same cycle, set wins.
- enable=0 in any state:
  - FSM goes to IDLE the next cycle; adc2tmu_en drops the same edge.
  - acc and cnt are cleared and the partial average is discarded.
  - An adc_done arriving later is ignored.
  - avg_valid/avg_data pending at that point are held until consumed.
- busy = (state != IDLE).

Optional Feature:
- Macro: ADC_TIMEOUT_EN.
- Defined: a counter runs in CONVERT. If TIMEOUT_CYC cycles elapse without adc_done:
  - err_timeout is set (sticky);
  - the sample is discarded (acc and cnt unchanged);
  - the FSM goes to WAIT_TICK.
  - An adc_done in the timeout cycle itself wins and no error is flagged.
- Not defined: CONVERT waits indefinitely. err_timeout is tied to 0; the port remains.

Test Plan:
- Reset with enable=1 held: all outputs 0 during reset. After release, adc2tmu_en=1 at cycle 1 and adc_start pulses at cycle 1+SETTLE_CYC+1.
- period=10, adc_done 3 cycles after each start, samples 100,101,102,105: adc_start spaced 10 cycles apart; avg_valid rises once with avg_data=102 (408>>2); busy=1 throughout.
- avg_ready held 0 across two full averages (first 0x800, then 0xFFF ×4): avg_data=0xFFF, avg_valid=1, overrun=1. ovr_clr pulse -> overrun=0.
- period=2, adc_done delayed 5 cycles after start: overrun=1 on the first missed tick; no extra adc_start is issued during CONVERT.
- enable dropped after 2 of 4 samples: adc2tmu_en=0 the next cycle, FSM back in IDLE. Re-enable and send 4 samples of 50: avg_data=50, with no contamination from the earlier samples.
- With ADC_TIMEOUT_EN, adc_done never asserted: err_timeout=1 after 255 cycles in CONVERT, and the next adc_start follows on the next tick. Without the macro, busy=1 and the FSM stays in CONVERT.
